test_rand_delay_source: RTL and testbench

Test-harness message source that replays a preloaded list of messages onto a val/rdy output interface. Between consecutive messages it inserts a pseudo-random number of idle cycles, bounded by a runtime `max_delay`. It is the producing counterpart to the random-delay test sink: tests drive a design under test from this block and drain it into the sink. Delay generation is built in (its own LFSR and counter), so it does not depend on a separate delay stage.

---
 rtl/test_rand_delay_source.sv | 100 ++++++++++
 tb/tb_test_rand_delay_source.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/test_rand_delay_source.sv
// rtl/test_rand_delay_source.sv - random-delay message source for test harnesses
// Replays a preloaded message list on a val/rdy port with LFSR-drawn idle gaps between messages.

module test_rand_delay_source #(
  parameter  int p_msg_nbits = 1,
  parameter  int p_num_msgs  = 1024,
  localparam int c_idx_nbits = $clog2(p_num_msgs)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [31:0]            max_delay_i,
  input  logic [c_idx_nbits:0]   num_msgs_i,
  input  logic                   load_en_i,
  input  logic [c_idx_nbits-1:0] load_addr_i,
  input  logic [p_msg_nbits-1:0] load_msg_i,
  output logic                   val_o,
  input  logic                   rdy_i,
  output logic [p_msg_nbits-1:0] msg_o,
  output logic                   done_o
);

  localparam logic [c_idx_nbits:0] c_num_max = (c_idx_nbits+1)'(p_num_msgs);
  localparam logic [c_idx_nbits:0] c_idx_one = (c_idx_nbits+1)'(1);
  localparam logic [31:0]          c_seed    = 32'hACE1_5EED;
  localparam logic [31:0]          c_mask    = 32'h8020_0003;

  typedef enum logic [1:0] {ST_WAIT, ST_SEND, ST_DONE} state_e;

  state_e                 state_q;
  logic [c_idx_nbits:0]   idx_q;
  logic [31:0]            cnt_q;
  logic [31:0]            lfsr_q;
  logic [p_msg_nbits-1:0] mem_q [p_num_msgs];

  logic [c_idx_nbits:0]   num_eff;
  logic [c_idx_nbits:0]   idx_d;
  logic [31:0]            lfsr_d;
  logic [32:0]            delay_d;
  logic                   fire;

  always_ff @(posedge clk_i) begin
    if (load_en_i) begin
      mem_q[load_addr_i] <= load_msg_i;
    end
  end

  // Delay is drawn at 33 bits so max_delay of all-ones still divides by 2^32, not by zero.
  always_comb begin
    num_eff = (num_msgs_i > c_num_max) ? c_num_max : num_msgs_i;
    idx_d   = idx_q + c_idx_one;
    lfsr_d  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? c_mask : 32'h0);
    delay_d = {1'b0, lfsr_q} % ({1'b0, max_delay_i} + 33'd1);
    fire    = (state_q == ST_SEND) && rdy_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_WAIT;
      idx_q   <= '0;
      cnt_q   <= '0;
      lfsr_q  <= c_seed;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (idx_q >= num_eff) begin
            state_q <= ST_DONE;
          end else if (cnt_q == 32'd0) begin
            state_q <= ST_SEND;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        ST_SEND: begin
          if (fire) begin
            idx_q  <= idx_d;
            lfsr_q <= lfsr_d;
            if (idx_d == num_eff) begin
              state_q <= ST_DONE;
            end else if (delay_d == 33'd0) begin
              state_q <= ST_SEND;
            end else begin
              cnt_q   <= delay_d[31:0] - 32'd1;
              state_q <= ST_WAIT;
            end
          end
        end
        ST_DONE: state_q <= ST_DONE;
        default: state_q <= ST_WAIT;
      endcase
    end
  end

  // idx_q < num_eff guarantees idx_q < p_num_msgs, so the low bits address the memory safely.
  always_comb begin
    val_o  = (state_q == ST_SEND);
    done_o = (state_q == ST_DONE);
    msg_o  = (idx_q < num_eff) ? mem_q[idx_q[c_idx_nbits-1:0]] : '0;
  end

endmodule

// File: tb/tb_test_rand_delay_source.sv
// tb/tb_test_rand_delay_source.sv - self-checking bench for test_rand_delay_source
// Cycle-level expectations come from an event-level replay model of messages, ready and delays.

module tb_test_rand_delay_source;

  localparam int W    = 8;
  localparam int N    = 32;
  localparam int IW   = $clog2(N);
  localparam int MAXC = 1024;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [31:0]   max_delay_i;
  logic [IW:0]   num_msgs_i;
  logic          load_en_i;
  logic [IW-1:0] load_addr_i;
  logic [W-1:0]  load_msg_i;
  logic          val_o;
  logic          rdy_i;
  logic [W-1:0]  msg_o;
  logic          done_o;

  always #5 clk_i = ~clk_i;

  test_rand_delay_source #(.p_msg_nbits(W), .p_num_msgs(N)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .max_delay_i (max_delay_i),
    .num_msgs_i  (num_msgs_i),
    .load_en_i   (load_en_i),
    .load_addr_i (load_addr_i),
    .load_msg_i  (load_msg_i),
    .val_o       (val_o),
    .rdy_i       (rdy_i),
    .msg_o       (msg_o),
    .done_o      (done_o)
  );

  logic [W-1:0] msgs     [N];
  bit           rdy_pat  [MAXC];
  bit           exp_val  [MAXC];
  bit           exp_done [MAXC];
  logic [W-1:0] exp_msg  [MAXC];
  int           fire_cyc [N];
  int           model_end;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Walk the message list: each message is offered until a ready cycle, then the next one
  // is offered 1+d cycles later, d drawn from the reference LFSR.
  task automatic build_model(input int nm_req, input logic [31:0] maxd);
    int          nm;
    int          k;
    longint      c;
    longint      d;
    logic [31:0] lfsr;
    nm   = (nm_req > N) ? N : nm_req;
    lfsr = 32'hACE1_5EED;
    for (int i = 0; i < MAXC; i++) begin
      exp_val[i]  = 1'b0;
      exp_done[i] = 1'b0;
      exp_msg[i]  = '0;
    end
    c = 1;
    for (k = 0; k < nm; k++) begin
      while (c < MAXC && !rdy_pat[int'(c)]) begin
        exp_val[int'(c)] = 1'b1;
        exp_msg[int'(c)] = msgs[k];
        c++;
      end
      if (c >= MAXC) break;
      exp_val[int'(c)] = 1'b1;
      exp_msg[int'(c)] = msgs[k];
      fire_cyc[k] = int'(c);
      d    = longint'(lfsr) % (longint'(maxd) + 1);
      lfsr = (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
      c    = (k == nm - 1) ? c + 1 : c + 1 + d;
    end
    if (k == nm && c < MAXC - 4) begin
      for (int i = int'(c); i < MAXC; i++) exp_done[i] = 1'b1;
      model_end = int'(c) + 4;
    end else begin
      model_end = 80;
    end
  endtask

  task automatic pulse_reset();
    reset_i = 1'b1;
    rdy_i   = 1'b0;
    @(posedge clk_i); #1;
    check_eq("rst_val", val_o, 0);
    check_eq("rst_done", done_o, 0);
    reset_i = 1'b0;
  endtask

  task automatic run(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      rdy_i = rdy_pat[c];
      check_eq($sformatf("val@%0d", c), val_o, exp_val[c]);
      check_eq($sformatf("done@%0d", c), done_o, exp_done[c]);
      if (exp_val[c] || exp_done[c])
        check_eq($sformatf("msg@%0d", c), msg_o, exp_msg[c]);
      @(posedge clk_i); #1;
    end
  endtask

  task automatic load_mem(input int n);
    reset_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      load_en_i   = 1'b1;
      load_addr_i = IW'(i);
      load_msg_i  = msgs[i];
      @(posedge clk_i); #1;
    end
    load_en_i = 1'b0;
  endtask

  task automatic set_rdy(input int pct_busy);
    for (int i = 0; i < MAXC; i++)
      rdy_pat[i] = (pct_busy == 0) ? 1'b1 : ($urandom_range(0, 99) >= pct_busy);
  endtask

  task automatic do_test(input int nm, input logic [31:0] maxd);
    num_msgs_i  = (IW+1)'(nm);
    max_delay_i = maxd;
    pulse_reset();
    build_model(nm, maxd);
    run(model_end);
  endtask

  initial begin
    logic [W-1:0] base;
    reset_i = 1'b1; rdy_i = 1'b0; load_en_i = 1'b0; load_addr_i = '0; load_msg_i = '0;
    max_delay_i = '0; num_msgs_i = '0;
    @(posedge clk_i); #1;

    msgs[0] = 8'h11; msgs[1] = 8'h22; msgs[2] = 8'h33; msgs[3] = 8'h44;
    load_mem(4);
    set_rdy(0);
    do_test(4, 0);

    set_rdy(0);
    rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b0; rdy_pat[4] = 1'b0;
    do_test(4, 0);

    base = W'($urandom);
    for (int i = 0; i < N; i++) msgs[i] = base + W'(i * 9);
    load_mem(N);
    set_rdy(0);
    do_test(32, 5);

    do_test(0, 7);

    set_rdy(30);
    do_test(32, 32'($urandom_range(0, 7)));

    set_rdy(25);
    num_msgs_i  = (IW+1)'(32);
    max_delay_i = 32'd4;
    pulse_reset();
    build_model(32, 32'd4);
    run(fire_cyc[9] + 1);
    pulse_reset();
    run(model_end);

    set_rdy(20);
    do_test(40, 1);

    set_rdy(0);
    do_test(2, 32'hFFFF_FFFF);

    for (int r = 0; r < 3; r++) begin
      set_rdy(40);
      do_test($urandom_range(1, N), 32'($urandom_range(0, 10)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
